// File: rtl/simple_pkg.sv
// Shared types and encodings for the SIMPLE pipeline hazard logic.
package simple_pkg;
  localparam int REG_AW = 3;

  localparam logic [1:0] MEMOP_NONE  = 2'b00;
  localparam logic [1:0] MEMOP_STORE = 2'b01;
  localparam logic [1:0] MEMOP_LOAD  = 2'b10;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic              valid;
    logic              writereg;
    logic [REG_AW-1:0] regaddress;
    logic              is_load;
  } sb_entry_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts cycles with inc=1 and holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use stall, branch flush and EX operand forwarding control for the
// 5-stage SIMPLE pipeline, driven by a 3-entry writer scoreboard (EX/MEM/WB).
module pipe_hazard_ctrl #(
  parameter int REG_AW = simple_pkg::REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic              id_rs_used,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic              id_rt_used,
  input  logic              id_writereg,
  input  logic [REG_AW-1:0] id_regaddress,
  input  logic [1:0]        id_memwrite,
  input  logic              ex_branch_taken,
  output logic              stall,
  output logic              flush,
  output logic              ex_bubble,
  output logic [1:0]        fwd_sel_a,
  output logic [1:0]        fwd_sel_b,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);
  import simple_pkg::*;

  sb_entry_t sb_ex, sb_mem, sb_wb, id_entry;
  logic      accept;

  function automatic logic hit(input sb_entry_t e, input logic [REG_AW-1:0] src);
    return e.valid & e.writereg & (e.regaddress == src);
  endfunction

  // Nearest producer wins; a WB writer is already visible through the
  // write-through register file, so it selects the regfile path.
  function automatic logic [1:0] fwd(input logic used, input logic [REG_AW-1:0] src,
                                     input sb_entry_t ex, input sb_entry_t mem,
                                     input sb_entry_t wb);
    if (!used)          return FWD_REG;
    if (hit(ex, src))   return FWD_EXMEM;
    if (hit(mem, src))  return FWD_MEMWB;
    if (hit(wb, src))   return FWD_REG;
    return FWD_REG;
  endfunction

  always_comb begin
    flush = ex_branch_taken;
    stall = id_valid & ~flush & sb_ex.valid & sb_ex.is_load & sb_ex.writereg &
            ((id_rs_used & (sb_ex.regaddress == id_rs_addr)) |
             (id_rt_used & (sb_ex.regaddress == id_rt_addr)));
    ex_bubble = stall | flush;
    accept    = id_valid & ~stall & ~flush;

    id_entry.valid      = accept;
    id_entry.writereg   = id_writereg;
    id_entry.regaddress = id_regaddress;
    id_entry.is_load    = (id_memwrite == MEMOP_LOAD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sb_ex     <= '0;
      sb_mem    <= '0;
      sb_wb     <= '0;
      fwd_sel_a <= FWD_REG;
      fwd_sel_b <= FWD_REG;
    end else begin
      sb_wb  <= sb_mem;
      sb_mem <= sb_ex;
      sb_ex  <= id_entry;
      if (accept) begin
        fwd_sel_a <= fwd(id_rs_used, id_rs_addr, sb_ex, sb_mem, sb_wb);
        fwd_sel_b <= fwd(id_rt_used, id_rt_addr, sb_ex, sb_mem, sb_wb);
      end else begin
        fwd_sel_a <= FWD_REG;
        fwd_sel_b <= FWD_REG;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .reset(reset), .inc(stall), .count(stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .reset(reset), .inc(flush), .count(flush_count)
  );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; narrow counters so saturation is reachable.
module tb_pipe_hazard_ctrl;
  localparam int AW = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid, id_rs_used, id_rt_used, id_writereg, ex_branch_taken;
  logic [AW-1:0] id_rs_addr, id_rt_addr, id_regaddress;
  logic [1:0]    id_memwrite;
  logic          stall, flush, ex_bubble;
  logic [1:0]    fwd_sel_a, fwd_sel_b;
  logic [CW-1:0] stall_count, flush_count;

  int n_cmp = 0;
  int n_err = 0;

  pipe_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .id_rt_addr(id_rt_addr), .id_rt_used(id_rt_used),
    .id_writereg(id_writereg), .id_regaddress(id_regaddress),
    .id_memwrite(id_memwrite), .ex_branch_taken(ex_branch_taken),
    .stall(stall), .flush(flush), .ex_bubble(ex_bubble),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic id_in(input logic v, input logic [AW-1:0] rs, input logic rsu,
                       input logic [AW-1:0] rt, input logic rtu,
                       input logic wr, input logic [AW-1:0] rd, input logic [1:0] mw);
    id_valid = v;   id_rs_addr = rs; id_rs_used = rsu;
    id_rt_addr = rt; id_rt_used = rtu;
    id_writereg = wr; id_regaddress = rd; id_memwrite = mw;
  endtask

  task automatic bubble_id();
    id_in(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 2'b00);
  endtask

  task automatic drain();
    bubble_id();
    repeat (3) step();
  endtask

  // One LD r4 followed by a dependent ADD: exactly one stall cycle.
  task automatic load_use();
    id_in(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 1'b1, 3'd4, 2'b10);
    step();
    id_in(1'b1, 3'd4, 1'b1, 3'd4, 1'b1, 1'b1, 3'd5, 2'b00);
    step();
    step();
  endtask

  initial begin
    reset = 1'b1;
    ex_branch_taken = 1'b0;
    bubble_id();
    step(); step();
    reset = 1'b0;
    #1;
    chk("rst_stall_cnt", stall_count, 0);
    chk("rst_flush_cnt", flush_count, 0);
    chk("rst_sel_a", fwd_sel_a, 0);
    chk("rst_sel_b", fwd_sel_b, 0);
    chk("rst_stall", stall, 0);

    // ADD r1,r2,r3 ; SUB r2,r1,r3
    id_in(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b1, 3'd1, 2'b00);
    step();
    id_in(1'b1, 3'd1, 1'b1, 3'd3, 1'b1, 1'b1, 3'd2, 2'b00);
    #1;
    chk("raw1_stall", stall, 0);
    step();
    chk("raw1_sel_a", fwd_sel_a, 1);
    chk("raw1_sel_b", fwd_sel_b, 0);
    drain();

    // ADD r1 ; NOP ; SUB r2,r3,r1
    id_in(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b1, 3'd1, 2'b00);
    step();
    bubble_id();
    step();
    id_in(1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 1'b1, 3'd2, 2'b00);
    step();
    chk("raw2_sel_a", fwd_sel_a, 0);
    chk("raw2_sel_b", fwd_sel_b, 2);
    drain();

    // ADD r1 ; NOP ; NOP ; consumer of r1 -> regfile
    id_in(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b1, 3'd1, 2'b00);
    step();
    bubble_id();
    step(); step();
    id_in(1'b1, 3'd1, 1'b1, 3'd1, 1'b1, 1'b1, 3'd6, 2'b00);
    step();
    chk("raw3_sel_a", fwd_sel_a, 0);
    chk("raw3_sel_b", fwd_sel_b, 0);
    drain();

    // LD r4 ; ADD r5,r4,r4
    id_in(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 1'b1, 3'd4, 2'b10);
    step();
    id_in(1'b1, 3'd4, 1'b1, 3'd4, 1'b1, 1'b1, 3'd5, 2'b00);
    #1;
    chk("lu_stall", stall, 1);
    chk("lu_bubble", ex_bubble, 1);
    step();
    chk("lu_stall_once", stall, 0);
    chk("lu_stall_cnt", stall_count, 1);
    chk("lu_bubble_sel_a", fwd_sel_a, 0);
    step();
    chk("lu_retry_sel_a", fwd_sel_a, 2);
    chk("lu_retry_sel_b", fwd_sel_b, 2);
    chk("lu_stall_cnt2", stall_count, 1);
    drain();

    // LD r4 in EX, dependent in ID, branch taken: flush wins
    id_in(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 1'b1, 3'd4, 2'b10);
    step();
    id_in(1'b1, 3'd4, 1'b1, 3'd0, 1'b0, 1'b1, 3'd5, 2'b00);
    ex_branch_taken = 1'b1;
    #1;
    chk("br_flush", flush, 1);
    chk("br_stall", stall, 0);
    chk("br_bubble", ex_bubble, 1);
    step();
    ex_branch_taken = 1'b0;
    chk("br_flush_cnt", flush_count, 1);
    chk("br_stall_cnt", stall_count, 1);
    chk("br_sel_a", fwd_sel_a, 0);
    // EX entry killed by flush, so the same consumer now sees LD in MEM
    #1;
    chk("br_no_stall_after", stall, 0);
    step();
    chk("br_after_sel_a", fwd_sel_a, 2);

    // back-to-back taken branches count individually
    ex_branch_taken = 1'b1;
    step(); step();
    ex_branch_taken = 1'b0;
    chk("br_b2b_cnt", flush_count, 3);
    drain();

    // store that happens to mark writereg never stalls
    id_in(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b1, 3'd6, 2'b01);
    step();
    id_in(1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 1'b1, 3'd7, 2'b00);
    #1;
    chk("st_no_stall", stall, 0);
    drain();

    // ADD r1 (MEM) ; ADD r1 (EX) ; consumer r1 -> youngest
    id_in(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b1, 3'd1, 2'b00);
    step();
    id_in(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b1, 3'd1, 2'b00);
    step();
    id_in(1'b1, 3'd1, 1'b1, 3'd1, 1'b1, 1'b1, 3'd3, 2'b00);
    step();
    chk("young_sel_a", fwd_sel_a, 1);
    chk("young_sel_b", fwd_sel_b, 1);
    drain();

    // saturate stall counter: 1 so far, 14 more reach 15 (all-ones)
    repeat (14) load_use();
    chk("sat_reach", stall_count, 15);
    load_use();
    chk("sat_hold", stall_count, 15);
    chk("sat_flush_keep", flush_count, 3);

    // reset in the middle of a stall
    id_in(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 1'b1, 3'd4, 2'b10);
    step();
    id_in(1'b1, 3'd4, 1'b1, 3'd4, 1'b1, 1'b1, 3'd5, 2'b00);
    #1;
    chk("mid_stall", stall, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("mid_rst_stall_cnt", stall_count, 0);
    chk("mid_rst_flush_cnt", flush_count, 0);
    chk("mid_rst_sel_a", fwd_sel_a, 0);
    chk("mid_rst_sel_b", fwd_sel_b, 0);
    chk("mid_rst_stall", stall, 0);

    // flush passes through during reset
    reset = 1'b1;
    ex_branch_taken = 1'b1;
    #1;
    chk("rst_flush_pass", flush, 1);
    step();
    ex_branch_taken = 1'b0;
    reset = 1'b0;
    chk("rst_flush_nocount", flush_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
